tdm_demux2: RTL and testbench
=============================

# tdm_demux2

Two-channel time-division demultiplexer: the receive end of a link where a 2:1 mux interleaves channel A and channel B samples onto one bus. It accepts a sample stream with a sync marker on every A sample. It locks to the A/B frame and routes each sample to a held, registered per-channel output with strobes. It also flags framing errors and counts completed pairs.

## Interface
- WIDTH, 8, sample width in bits
- CNT_W, 8, width of completed-pair counter
- Clk  input  1  rising-edge clock
- Rst  input  1  synchronous, active-high reset
- D  input  WIDTH  multiplexed sample bus
- DValid  input  1  D carries a sample this cycle
- Sync  input  1  qualifies D as a channel-A sample; ignored when DValid=0
- A  output  WIDTH  last captured channel-A sample, held
- B  output  WIDTH  last captured channel-B sample, held
- AValid  output  1  one-cycle pulse: A updated this cycle
- BValid  output  1  one-cycle pulse: B updated this cycle
- PairValid  output  1  one-cycle pulse: A/B now form a complete frame
- Locked  output  1  FSM is frame-aligned (state ≠ UNLOCKED)
- SyncErr  output  1  one-cycle pulse: framing violation detected
- PairCnt  output  CNT_W  completed pairs since reset, wraps

## Operation
- FSM states: UNLOCKED, EXPECT_B, EXPECT_A.
- Only cycles with DValid=1 are "accepted" samples. DValid=0 changes no state and pulses nothing.
- UNLOCKED:
  - Sync=1 → capture A, pulse AValid, go EXPECT_B.
  - Sync=0 → discard, stay.
- EXPECT_B:
  - Sync=0 → capture B, pulse BValid and PairValid, increment PairCnt, go EXPECT_A.
  - Sync=1 → pulse SyncErr, capture D as new A, pulse AValid, stay EXPECT_B.
- EXPECT_A:
  - Sync=1 → capture A, pulse AValid, go EXPECT_B.
  - Sync=0 → pulse SyncErr, discard, go UNLOCKED.
- A and B registers change only on capture. They hold across gaps, errors and loss of lock.
- PairCnt wraps from 2^CNT_W−1 to 0 and raises no flag. PairCnt does not reset on SyncErr.
- Locked=1 in EXPECT_A and EXPECT_B.

## Timing
- All outputs registered. An accepted sample at edge n is visible on A/B and the strobes after edge n; the strobes are high for exactly one cycle.
- Back-to-back samples (DValid=1 every cycle) are supported at full rate, one sample per cycle.
- Rst=1 at an edge forces:
  - state UNLOCKED
  - A=0, B=0
  - AValid=BValid=PairValid=SyncErr=0
  - Locked=0
  - PairCnt=0
- Rst overrides any concurrent sample. Reset mid-frame discards a pending A; no PairValid follows.
- PairValid and BValid are always coincident. AValid is never coincident with BValid.
- SyncErr can coincide with AValid (duplicate-A case) but never with BValid.

## Structure
- Shared header tdm_defs.vh holds the state encodings (UNLOCKED=2'd0, EXPECT_B=2'd1, EXPECT_A=2'd2) and the WIDTH/CNT_W defaults.
- One sub-module, tdm_chan_reg, is instantiated twice (A and B). It holds a WIDTH-bit capture register plus a one-cycle valid strobe, and has a load enable.
- FSM, error logic and PairCnt live in tdm_demux2.

## Test plan
- Reset then frames (D=8'h11,Sync=1),(D=8'h22,Sync=0) → AValid then A=11; BValid+PairValid with B=22; Locked=1; PairCnt=1.
- Gaps: A=8'h33, three DValid=0 cycles, B=8'h44 → A, B and Locked hold through the gap; a single PairValid with A=33,B=44; no SyncErr.
- Two Sync=1 samples 8'h55, 8'h66 → SyncErr+AValid on the second; A=66; next B=8'h77 gives PairValid with A=66,B=77.
- After a complete pair, a Sync=0 sample 8'h99 → SyncErr, Locked=0, B stays at its old value; subsequent Sync=0 samples are ignored until Sync=1.
- 256 continuous pairs with CNT_W=8 → PairCnt returns to 0 after the 256th PairValid.
- Rst asserted in EXPECT_B with DValid=1 on the same edge → all outputs 0 next cycle, no BValid; next frame relocks normally.

Source files
------------

// File: rtl/tdm_demux2_pkg.sv
// Shared definitions for the two-channel TDM demultiplexer: frame-tracking
// state encodings and default widths.
package tdm_demux2_pkg;

  localparam int WIDTH_DEF = 8;
  localparam int CNT_W_DEF = 8;

  typedef enum logic [1:0] {
    UNLOCKED = 2'd0,
    EXPECT_B = 2'd1,
    EXPECT_A = 2'd2
  } tdm_state_t;

endpackage

// File: rtl/tdm_demux2_if.sv
// Bus bundle between the multiplexed sample source and the demultiplexer.
// The slave side is the demultiplexer; the master side is the link/consumer.
interface tdm_demux2_if
  import tdm_demux2_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int CNT_W = CNT_W_DEF
);

  logic [WIDTH-1:0] d;
  logic             dvalid;
  logic             sync;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             avalid;
  logic             bvalid;
  logic             pairvalid;
  logic             locked;
  logic             syncerr;
  logic [CNT_W-1:0] paircnt;

  modport master (
    output d, dvalid, sync,
    input  a, b, avalid, bvalid, pairvalid, locked, syncerr, paircnt
  );

  modport slave (
    input  d, dvalid, sync,
    output a, b, avalid, bvalid, pairvalid, locked, syncerr, paircnt
  );

endinterface

// File: rtl/tdm_demux2_chan_reg.sv
// Per-channel capture register: holds the last loaded sample and raises a
// one-cycle strobe on the cycle after each load.
module tdm_chan_reg
  import tdm_demux2_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             vld
);

  logic [WIDTH-1:0] data_p0;
  logic             vld_p0;

  // Stage p0: capture register and strobe
  always_ff @(posedge clk) begin
    if (rst) begin
      data_p0 <= '0;
      vld_p0  <= 1'b0;
    end else begin
      vld_p0 <= load;
      if (load) data_p0 <= din;
    end
  end

  assign dout = data_p0;
  assign vld  = vld_p0;

endmodule

// File: rtl/tdm_demux2.sv
// Two-channel TDM demultiplexer: locks to the A/B frame using the sync
// marker on A samples, routes samples to held per-channel outputs.
module tdm_demux2
  import tdm_demux2_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic          clk,
  input  logic          rst,
  tdm_demux2_if.slave   bus
);

  tdm_state_t       state_p0, state_nxt;
  logic             load_a, load_b, err_nxt;
  logic             syncerr_p0;
  logic [CNT_W-1:0] paircnt_p0;
  logic             bvld;

  // Next-state and capture decisions; idle cycles leave everything as is
  always_comb begin
    state_nxt = state_p0;
    load_a    = 1'b0;
    load_b    = 1'b0;
    err_nxt   = 1'b0;
    if (bus.dvalid) begin
      unique case (state_p0)
        UNLOCKED: begin
          if (bus.sync) begin
            load_a    = 1'b1;
            state_nxt = EXPECT_B;
          end
        end
        EXPECT_B: begin
          if (bus.sync) begin
            // duplicate A: flag it but resynchronise on the newer sample
            err_nxt = 1'b1;
            load_a  = 1'b1;
          end else begin
            load_b    = 1'b1;
            state_nxt = EXPECT_A;
          end
        end
        EXPECT_A: begin
          if (bus.sync) begin
            load_a    = 1'b1;
            state_nxt = EXPECT_B;
          end else begin
            err_nxt   = 1'b1;
            state_nxt = UNLOCKED;
          end
        end
        default: state_nxt = UNLOCKED;
      endcase
    end
  end

  // Stage p0: frame state, error strobe and pair counter
  always_ff @(posedge clk) begin
    if (rst) begin
      state_p0   <= UNLOCKED;
      syncerr_p0 <= 1'b0;
      paircnt_p0 <= '0;
    end else begin
      state_p0   <= state_nxt;
      syncerr_p0 <= err_nxt;
      if (load_b) paircnt_p0 <= paircnt_p0 + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

  tdm_chan_reg #(.WIDTH(WIDTH)) u_chan_a (
    .clk  (clk),
    .rst  (rst),
    .load (load_a),
    .din  (bus.d),
    .dout (bus.a),
    .vld  (bus.avalid)
  );

  tdm_chan_reg #(.WIDTH(WIDTH)) u_chan_b (
    .clk  (clk),
    .rst  (rst),
    .load (load_b),
    .din  (bus.d),
    .dout (bus.b),
    .vld  (bvld)
  );

  // A B capture always completes a frame, so the pair strobe is the B strobe
  assign bus.bvalid    = bvld;
  assign bus.pairvalid = bvld;
  assign bus.locked    = (state_p0 != UNLOCKED);
  assign bus.syncerr   = syncerr_p0;
  assign bus.paircnt   = paircnt_p0;

endmodule

// File: tb/tb_tdm_demux2.sv
// Scoreboard bench for tdm_demux2: a behavioural frame model pushes the
// expected outputs per driven cycle; each scenario pops and compares them.
module tb_tdm_demux2;

  localparam int WIDTH = 8;
  localparam int CNT_W = 8;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  tdm_demux2_if #(.WIDTH(WIDTH), .CNT_W(CNT_W)) bus ();

  tdm_demux2 #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // {a, b, avalid, bvalid, pairvalid, locked, syncerr, paircnt}
  typedef logic [2*WIDTH+5+CNT_W-1:0] obs_t;

  obs_t sb[$];
  int   checks   = 0;
  int   failures = 0;

  int               m_st;
  logic [WIDTH-1:0] m_a, m_b;
  logic [CNT_W-1:0] m_cnt;

  function automatic obs_t observe();
    return {bus.a, bus.b, bus.avalid, bus.bvalid, bus.pairvalid,
            bus.locked, bus.syncerr, bus.paircnt};
  endfunction

  // Drive one cycle, predict the registered outputs, sample #1 after the edge
  task automatic drive(input logic r, input logic dv, input logic sy,
                       input logic [WIDTH-1:0] dd);
    logic av, bv, se;
    @(negedge clk);
    rst = r; bus.dvalid = dv; bus.sync = sy; bus.d = dd;
    av = 1'b0; bv = 1'b0; se = 1'b0;
    if (r) begin
      m_st = 0; m_a = '0; m_b = '0; m_cnt = '0;
    end else if (dv) begin
      case (m_st)
        0: if (sy) begin m_a = dd; av = 1'b1; m_st = 1; end
        1: if (!sy) begin m_b = dd; bv = 1'b1; m_cnt = m_cnt + 1'b1; m_st = 2; end
           else begin se = 1'b1; m_a = dd; av = 1'b1; end
        default: if (sy) begin m_a = dd; av = 1'b1; m_st = 1; end
                 else begin se = 1'b1; m_st = 0; end
      endcase
    end
    sb.push_back({m_a, m_b, av, bv, bv, (m_st != 0), se, m_cnt});
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    obs_t e;
    drive(1'b1, 1'b0, 1'b0, '0);
    e = sb.pop_front();
    checks++;
    if (observe() !== e) begin
      failures++; $display("FAIL reset_sb got=%h exp=%h", observe(), e);
    end
    checks++;
    if (observe() !== '0) begin
      failures++; $display("FAIL reset_zero got=%h exp=0", observe());
    end
  endtask

  task automatic test_basic();
    obs_t e;
    drive(1'b0, 1'b1, 1'b1, 8'h11);
    e = sb.pop_front();
    checks++;
    if (observe() !== e) begin
      failures++; $display("FAIL basic_a_sb got=%h exp=%h", observe(), e);
    end
    checks++;
    if ({bus.a, bus.avalid, bus.bvalid} !== {8'h11, 1'b1, 1'b0}) begin
      failures++; $display("FAIL basic_a got=%h/%b/%b exp=11/1/0", bus.a, bus.avalid, bus.bvalid);
    end
    drive(1'b0, 1'b1, 1'b0, 8'h22);
    e = sb.pop_front();
    checks++;
    if (observe() !== e) begin
      failures++; $display("FAIL basic_b_sb got=%h exp=%h", observe(), e);
    end
    checks++;
    if ({bus.b, bus.bvalid, bus.pairvalid, bus.locked, bus.paircnt} !== {8'h22, 3'b111, 8'd1}) begin
      failures++;
      $display("FAIL basic_b got=b%h bv%b pv%b lk%b cnt%0d exp=b22 1 1 1 cnt1",
               bus.b, bus.bvalid, bus.pairvalid, bus.locked, bus.paircnt);
    end
  endtask

  task automatic test_gaps();
    obs_t e;
    int   pv = 0, se = 0;
    logic [2:0] dv_t[5]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
    logic       sy_t[5]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    logic [7:0] d_t[5]   = '{8'h33, 8'hEE, 8'hEE, 8'hEE, 8'h44};
    for (int i = 0; i < 5; i++) begin
      drive(1'b0, dv_t[i][0], sy_t[i], d_t[i]);
      e = sb.pop_front();
      pv += int'(bus.pairvalid);
      se += int'(bus.syncerr);
      checks++;
      if (observe() !== e) begin
        failures++; $display("FAIL gaps_sb[%0d] got=%h exp=%h", i, observe(), e);
      end
      if (i >= 1 && i <= 3) begin
        checks++;
        if ({bus.a, bus.locked, bus.avalid} !== {8'h33, 1'b1, 1'b0}) begin
          failures++; $display("FAIL gaps_hold[%0d] got=a%h lk%b av%b exp=a33 1 0", i, bus.a, bus.locked, bus.avalid);
        end
      end
    end
    checks++;
    if ({pv, se, bus.a, bus.b} !== {32'd1, 32'd0, 8'h33, 8'h44}) begin
      failures++; $display("FAIL gaps_pair got=pv%0d se%0d a%h b%h exp=pv1 se0 a33 b44", pv, se, bus.a, bus.b);
    end
  endtask

  task automatic test_dup_a();
    obs_t e;
    logic       sy_t[3] = '{1'b1, 1'b1, 1'b0};
    logic [7:0] d_t[3]  = '{8'h55, 8'h66, 8'h77};
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, 1'b1, sy_t[i], d_t[i]);
      e = sb.pop_front();
      checks++;
      if (observe() !== e) begin
        failures++; $display("FAIL dup_sb[%0d] got=%h exp=%h", i, observe(), e);
      end
      if (i == 1) begin
        checks++;
        if ({bus.syncerr, bus.avalid, bus.a} !== {2'b11, 8'h66}) begin
          failures++; $display("FAIL dup_err got=se%b av%b a%h exp=1 1 66", bus.syncerr, bus.avalid, bus.a);
        end
      end
    end
    checks++;
    if ({bus.pairvalid, bus.a, bus.b, bus.syncerr} !== {1'b1, 8'h66, 8'h77, 1'b0}) begin
      failures++; $display("FAIL dup_pair got=pv%b a%h b%h se%b exp=1 66 77 0", bus.pairvalid, bus.a, bus.b, bus.syncerr);
    end
  endtask

  task automatic test_loss();
    obs_t e;
    logic [7:0] d_t[3] = '{8'h99, 8'hA1, 8'hA2};
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, 1'b1, 1'b0, d_t[i]);
      e = sb.pop_front();
      checks++;
      if (observe() !== e) begin
        failures++; $display("FAIL loss_sb[%0d] got=%h exp=%h", i, observe(), e);
      end
      checks++;
      if ({bus.syncerr, bus.locked, bus.b, bus.bvalid, bus.avalid} !== {(i == 0), 1'b0, 8'h77, 2'b00}) begin
        failures++;
        $display("FAIL loss[%0d] got=se%b lk%b b%h bv%b av%b exp=se%0d 0 77 0 0",
                 i, bus.syncerr, bus.locked, bus.b, bus.bvalid, bus.avalid, (i == 0));
      end
    end
  endtask

  task automatic test_wrap();
    obs_t e;
    int   pv = 0;
    logic [7:0] r;
    drive(1'b1, 1'b0, 1'b0, '0);
    void'(sb.pop_front());
    for (int i = 0; i < 256; i++) begin
      for (int k = 0; k < 2; k++) begin
        r = 8'($urandom_range(0, 255));
        drive(1'b0, 1'b1, (k == 0), r);
        e = sb.pop_front();
        pv += int'(bus.pairvalid);
        checks++;
        if (observe() !== e) begin
          failures++; $display("FAIL wrap_sb[%0d.%0d] got=%h exp=%h", i, k, observe(), e);
        end
      end
    end
    checks++;
    if ({pv, bus.paircnt, bus.pairvalid} !== {32'd256, 8'd0, 1'b1}) begin
      failures++; $display("FAIL wrap_cnt got=pv%0d cnt%0d exp=pv256 cnt0", pv, bus.paircnt);
    end
  endtask

  task automatic test_reset_mid();
    obs_t e;
    drive(1'b0, 1'b1, 1'b1, 8'hC1);
    void'(sb.pop_front());
    drive(1'b1, 1'b1, 1'b0, 8'hC2);
    e = sb.pop_front();
    checks++;
    if (observe() !== e || observe() !== '0) begin
      failures++; $display("FAIL rstmid_zero got=%h exp=0", observe());
    end
    drive(1'b0, 1'b0, 1'b0, 8'h00);
    e = sb.pop_front();
    checks++;
    if (observe() !== e || bus.pairvalid !== 1'b0) begin
      failures++; $display("FAIL rstmid_nopair got=%h exp=%h", observe(), e);
    end
    drive(1'b0, 1'b1, 1'b1, 8'hD1);
    void'(sb.pop_front());
    drive(1'b0, 1'b1, 1'b0, 8'hD2);
    e = sb.pop_front();
    checks++;
    if (observe() !== e || {bus.a, bus.b, bus.pairvalid, bus.locked, bus.paircnt} !== {8'hD1, 8'hD2, 2'b11, 8'd1}) begin
      failures++; $display("FAIL rstmid_relock got=%h exp=%h", observe(), e);
    end
  endtask

  initial begin
    bus.d = '0; bus.dvalid = 1'b0; bus.sync = 1'b0;
    m_st = 0; m_a = '0; m_b = '0; m_cnt = '0;
    test_reset();
    test_basic();
    test_gaps();
    test_dup_a();
    test_loss();
    test_wrap();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
